// File: rtl/riscv_writeback_arb.sv
// Register-file write-port arbiter: exec > LSU FIFO head > mul/div,
// one registered write per cycle plus a pending-write mask.
module riscv_writeback_arb #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               exec_valid_i,
  input  logic [4:0]         exec_rd_i,
  input  logic [31:0]        exec_value_i,
  input  logic               lsu_valid_i,
  input  logic [4:0]         lsu_rd_i,
  input  logic [31:0]        lsu_value_i,
  output logic               lsu_ready_o,
  input  logic               muldiv_valid_i,
  input  logic [4:0]         muldiv_rd_i,
  input  logic [31:0]        muldiv_value_i,
  output logic               muldiv_ready_o,
  output logic [4:0]         rd0_o,
  output logic [31:0]        rd0_value_o,
  output logic [31:0]        pending_o,
  output logic [FIFO_AW:0]   fifo_level_o
);

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [4:0]         rd0_q, rd0_d;
  logic [31:0]        val0_q, val0_d;
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [4:0]         frd_q  [FIFO_DEPTH];
  logic [31:0]        fval_q [FIFO_DEPTH];

  logic full, empty, push, pop, mul_take;
  logic [FIFO_AW-1:0] off;
  logic [31:0]        pend;

  always_comb begin
    full           = (cnt_q == DEPTH_C);
    empty          = (cnt_q == '0);
    lsu_ready_o    = rst_i & ~full;
    muldiv_ready_o = rst_i & ~exec_valid_i & empty;
    push           = lsu_valid_i & lsu_ready_o & (lsu_rd_i != '0);
    pop            = ~exec_valid_i & ~empty;
    mul_take       = muldiv_valid_i & muldiv_ready_o;
  end

  // Arms are mutually exclusive: pop and mul_take both need !exec,
  // and mul_take additionally needs an empty FIFO.
  always_comb begin
    rd0_d  = '0;
    val0_d = '0;
    unique case (1'b1)
      exec_valid_i: begin
        rd0_d  = exec_rd_i;
        val0_d = (exec_rd_i != '0) ? exec_value_i : '0;
      end
      pop: begin
        rd0_d  = frd_q[rptr_q];
        val0_d = fval_q[rptr_q];
      end
      mul_take: begin
        rd0_d  = muldiv_rd_i;
        val0_d = (muldiv_rd_i != '0) ? muldiv_value_i : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd0_q  <= '0;
      val0_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rd0_q  <= rd0_d;
      val0_q <= val0_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage needs no reset; validity comes from rptr/count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      frd_q[wptr_q]  <= lsu_rd_i;
      fval_q[wptr_q] <= lsu_value_i;
    end
  end

  always_comb begin
    pend = '0;
    off  = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = FIFO_AW'(i) - rptr_q;
      if ({1'b0, off} < cnt_q) pend[frd_q[i]] = 1'b1;
    end
    pend[rd0_q] = 1'b1;
    pend[0]     = 1'b0;
  end

  assign pending_o    = pend;
  assign rd0_o        = rd0_q;
  assign rd0_value_o  = val0_q;
  assign fifo_level_o = cnt_q;

endmodule

// File: tb/tb_riscv_writeback_arb.sv
// Directed bench for riscv_writeback_arb: priority, FIFO order,
// x0 filter, pending mask and asynchronous reset.
module tb_riscv_writeback_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        exec_valid_i;
  logic [4:0]  exec_rd_i;
  logic [31:0] exec_value_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_value_i;
  logic        lsu_ready_o;
  logic        muldiv_valid_i;
  logic [4:0]  muldiv_rd_i;
  logic [31:0] muldiv_value_i;
  logic        muldiv_ready_o;
  logic [4:0]  rd0_o;
  logic [31:0] rd0_value_o;
  logic [31:0] pending_o;
  logic [2:0]  fifo_level_o;

  int nvec = 0;
  int nerr = 0;

  riscv_writeback_arb #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .exec_valid_i(exec_valid_i), .exec_rd_i(exec_rd_i),
    .exec_value_i(exec_value_i),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i),
    .lsu_value_i(lsu_value_i), .lsu_ready_o(lsu_ready_o),
    .muldiv_valid_i(muldiv_valid_i), .muldiv_rd_i(muldiv_rd_i),
    .muldiv_value_i(muldiv_value_i),
    .muldiv_ready_o(muldiv_ready_o),
    .rd0_o(rd0_o), .rd0_value_o(rd0_value_o),
    .pending_o(pending_o), .fifo_level_o(fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    exec_valid_i   = 1'b0;
    lsu_valid_i    = 1'b0;
    muldiv_valid_i = 1'b0;
  endtask

  task automatic exec(input logic [4:0] rd, input logic [31:0] v);
    exec_valid_i = 1'b1;
    exec_rd_i    = rd;
    exec_value_i = v;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] v);
    lsu_valid_i = 1'b1;
    lsu_rd_i    = rd;
    lsu_value_i = v;
  endtask

  initial begin
    rst_i = 1'b0;
    idle();
    exec_rd_i = '0; exec_value_i = '0;
    lsu_rd_i = '0; lsu_value_i = '0;
    muldiv_rd_i = '0; muldiv_value_i = '0;
    #3;
    chk("rst_rd0", 32'(rd0_o), 32'd0);
    chk("rst_val", rd0_value_o, 32'd0);
    chk("rst_pend", pending_o, 32'd0);
    chk("rst_lvl", 32'(fifo_level_o), 32'd0);
    chk("rst_lrdy", 32'(lsu_ready_o), 32'd0);
    chk("rst_mrdy", 32'(muldiv_ready_o), 32'd0);
    #9 rst_i = 1'b1;
    tick();
    chk("idle_lrdy", 32'(lsu_ready_o), 32'd1);
    chk("idle_mrdy", 32'(muldiv_ready_o), 32'd1);

    // 1: exec latency and single-cycle hold
    exec(5'd5, 32'hDEADBEEF);
    tick();
    chk("t1_rd0", 32'(rd0_o), 32'd5);
    chk("t1_val", rd0_value_o, 32'hDEADBEEF);
    chk("t1_pend", pending_o, 32'h0000_0020);
    idle();
    tick();
    chk("t1_rd0_clr", 32'(rd0_o), 32'd0);
    chk("t1_val_clr", rd0_value_o, 32'd0);

    // 2: exec > lsu > muldiv
    exec(5'd3, 32'h33);
    lsu(5'd7, 32'h11);
    muldiv_valid_i = 1'b1;
    muldiv_rd_i    = 5'd9;
    muldiv_value_i = 32'h99;
    #1;
    chk("t2_lrdy", 32'(lsu_ready_o), 32'd1);
    chk("t2_mrdy0", 32'(muldiv_ready_o), 32'd0);
    tick();
    chk("t2_rd0_a", 32'(rd0_o), 32'd3);
    chk("t2_lvl1", 32'(fifo_level_o), 32'd1);
    exec_valid_i = 1'b0;
    lsu_valid_i  = 1'b0;
    #1;
    chk("t2_mrdy1", 32'(muldiv_ready_o), 32'd0);
    chk("t2_pend", pending_o, 32'h0000_0088);
    tick();
    chk("t2_rd0_b", 32'(rd0_o), 32'd7);
    chk("t2_val_b", rd0_value_o, 32'h11);
    chk("t2_lvl0", 32'(fifo_level_o), 32'd0);
    chk("t2_mrdy2", 32'(muldiv_ready_o), 32'd1);
    tick();
    chk("t2_rd0_c", 32'(rd0_o), 32'd9);
    chk("t2_val_c", rd0_value_o, 32'h99);
    muldiv_valid_i = 1'b0;
    tick();
    chk("t2_rd0_d", 32'(rd0_o), 32'd0);

    // 3: fill FIFO under exec, strict full, drain with push+pop and wrap
    for (int k = 0; k < 4; k++) begin
      exec(5'd1, 32'(k));
      lsu(5'(20 + k), 32'hA0 + 32'(k));
      tick();
      chk("t3_fill_rd0", 32'(rd0_o), 32'd1);
    end
    chk("t3_lvl4", 32'(fifo_level_o), 32'd4);
    lsu(5'd24, 32'hA4);
    #1;
    chk("t3_lrdy_full", 32'(lsu_ready_o), 32'd0);
    chk("t3_pend", pending_o, 32'h00F0_0002);
    tick();
    chk("t3_lvl_strict", 32'(fifo_level_o), 32'd4);
    idle();
    tick();
    chk("t3_d0_rd", 32'(rd0_o), 32'd20);
    chk("t3_d0_val", rd0_value_o, 32'hA0);
    chk("t3_d0_lvl", 32'(fifo_level_o), 32'd3);
    lsu(5'd25, 32'hA5);
    tick();
    chk("t3_d1_rd", 32'(rd0_o), 32'd21);
    chk("t3_d1_val", rd0_value_o, 32'hA1);
    chk("t3_d1_lvl", 32'(fifo_level_o), 32'd3);
    idle();
    tick();
    chk("t3_d2_rd", 32'(rd0_o), 32'd22);
    chk("t3_d2_lvl", 32'(fifo_level_o), 32'd2);
    tick();
    chk("t3_d3_rd", 32'(rd0_o), 32'd23);
    chk("t3_d3_val", rd0_value_o, 32'hA3);
    chk("t3_d3_lvl", 32'(fifo_level_o), 32'd1);
    tick();
    chk("t3_d4_rd", 32'(rd0_o), 32'd25);
    chk("t3_d4_val", rd0_value_o, 32'hA5);
    chk("t3_d4_lvl", 32'(fifo_level_o), 32'd0);
    tick();
    chk("t3_end_rd", 32'(rd0_o), 32'd0);

    // 4: x0 filter on LSU
    lsu(5'd0, 32'h1234);
    #1;
    chk("t4_lrdy", 32'(lsu_ready_o), 32'd1);
    tick();
    chk("t4_lvl", 32'(fifo_level_o), 32'd0);
    chk("t4_rd0", 32'(rd0_o), 32'd0);
    idle();
    tick();
    chk("t4_rd0_b", 32'(rd0_o), 32'd0);
    chk("t4_pend", pending_o, 32'd0);

    // 5: pending lifetime of a queued load
    exec(5'd2, 32'h22);
    lsu(5'd12, 32'hC);
    tick();
    chk("t5_pend_q", pending_o, 32'h0000_1004);
    idle();
    tick();
    chk("t5_rd0", 32'(rd0_o), 32'd12);
    chk("t5_pend_o", pending_o, 32'h0000_1000);
    tick();
    chk("t5_pend_clr", pending_o, 32'd0);

    // 6: asynchronous reset with two queued entries
    exec(5'd4, 32'h44);
    lsu(5'd13, 32'hD);
    tick();
    lsu(5'd14, 32'hE);
    tick();
    chk("t6_lvl2", 32'(fifo_level_o), 32'd2);
    #2 rst_i = 1'b0;
    idle();
    #1;
    chk("t6_rd0", 32'(rd0_o), 32'd0);
    chk("t6_pend", pending_o, 32'd0);
    chk("t6_lvl", 32'(fifo_level_o), 32'd0);
    chk("t6_lrdy", 32'(lsu_ready_o), 32'd0);
    #3 rst_i = 1'b1;
    tick();
    chk("t6_post_rd0", 32'(rd0_o), 32'd0);
    tick();
    chk("t6_post_rd0b", 32'(rd0_o), 32'd0);
    chk("t6_post_lvl", 32'(fifo_level_o), 32'd0);
    chk("t6_post_pend", pending_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
